param_icache: RTL and testbench
===============================

PARAM_ICACHE -- requirements
Module: param_icache

Interface
REQ-001 Parameter: WORD_SIZE, 16, width of address and data words.
REQ-002 Parameter: NUM_SETS, 4, number of sets; power of two, at least 2.
REQ-003 Parameter: WORDS_PER_LINE, 4, words per line; power of two, at least 2.
REQ-004 Parameter: NUM_WAYS, 2, associativity; legal values are 1 and 2.
REQ-005 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: req_valid  in  1  fetch request.
REQ-008 Port: req_addr  in  WORD_SIZE  word address of the fetch.
REQ-009 Port: req_ready  out  1  cache can accept a request this cycle.
REQ-010 Port: resp_valid  out  1  one-cycle pulse; resp_data is valid.
REQ-011 Port: resp_data  out  WORD_SIZE  fetched instruction word.
REQ-012 Port: mem_req  out  1  line-fill request, held for the whole fill.
REQ-013 Port: mem_addr  out  WORD_SIZE  line-aligned base address of the fill.
REQ-014 Port: mem_valid  in  1  one fill beat is present on mem_data.
REQ-015 Port: mem_data  in  WORD_SIZE  fill beat; beats arrive in ascending word order.
REQ-016 Port: flush  in  1  invalidate all lines.
REQ-017 Port: hit_count, miss_count  out  16 each  saturating statistics counters.

Function
REQ-018 Address split SHALL be: offset = low log2(WORDS_PER_LINE) bits; index = next log2(NUM_SETS) bits; tag = the remaining upper bits.
REQ-019 Each way/set SHALL hold: a valid bit, a tag, and WORDS_PER_LINE data words; each set SHALL hold one LRU bit when NUM_WAYS=2.
REQ-020 FSM states SHALL be IDLE, LOOKUP and FILL.
REQ-021 req_ready SHALL be 1 only in IDLE with no flush pending and flush low.
REQ-022 IDLE: on req_valid && req_ready, the cache SHALL register req_addr and go to LOOKUP.
REQ-023 LOOKUP: hit = any way with valid set and matching tag.
REQ-024 LOOKUP on hit: next cycle SHALL be IDLE with resp_valid=1 and resp_data = the hit word; the hit way becomes MRU; hit_count increments.
REQ-025 Hit latency SHALL be 2 cycles from the accept edge to the resp_valid cycle; back-to-back hits are allowed (req_ready=1 during the resp_valid cycle).
REQ-026 LOOKUP on miss: next state SHALL be FILL; miss_count increments.
REQ-027 Victim selection SHALL be: the first invalid way (way 0 first); otherwise the LRU way. With NUM_WAYS=1 the victim is always way 0.
REQ-028 FILL: mem_req=1 and mem_addr = registered address with offset bits zeroed.
REQ-029 FILL: each mem_valid beat SHALL be written to victim word beat_cnt, then beat_cnt increments; cycles with mem_valid low SHALL not advance the fill.
REQ-030 The beat whose beat_cnt equals the requested offset SHALL be captured for the response.
REQ-031 On the last beat (beat_cnt = WORDS_PER_LINE-1), the cache SHALL:
- set valid and tag;
- mark the victim MRU;
- go to IDLE with resp_valid=1 and resp_data = the captured word.
REQ-032 mem_req SHALL fall in the cycle after the last beat; mem_valid outside FILL SHALL be ignored.
REQ-033 Miss latency SHALL be 2 + (cycles to deliver WORDS_PER_LINE beats) cycles.
REQ-034 flush high in any cycle SHALL set flush_pending.
REQ-035 flush_pending SHALL be applied in the first IDLE cycle: all valid bits clear on that edge, no request is accepted on that edge, and flush_pending clears.
REQ-036 A fill in progress when flush arrives SHALL complete and respond; the line is then invalidated by REQ-035.
REQ-037 hit_count and miss_count SHALL saturate at 0xFFFF.
REQ-038 resp_valid SHALL be 0 in every cycle except the REQ-024 and REQ-031 pulses.

Reset
REQ-039 A synchronous reset SHALL set the following, regardless of state (including mid-fill):
- state=IDLE, all valid bits=0, all LRU bits=0, beat_cnt=0, flush_pending=0;
- hit_count=0, miss_count=0;
- req_ready=1, resp_valid=0, resp_data=0, mem_req=0, mem_addr=0.
REQ-040 Data and tag arrays SHALL not need reset.

Verification
REQ-041 Cold miss: request 0x0012 -> mem_req=1 with mem_addr=0x0010; beats A0..A3 -> resp_data=A2, miss_count=1. Then request 0x0013 -> resp_valid 2 cycles after accept, resp_data=A3, hit_count=1.
REQ-042 LRU: fill 0x0000, then 0x0040 (same set), hit 0x0000, miss 0x0080 -> 0x0040 is evicted. Then 0x0000 hits and 0x0040 misses.
REQ-043 Flush mid-fill: flush pulse at beat 1 of the 0x0020 fill -> response still delivered; next 0x0020 request misses (mem_req=1).
REQ-044 Reset after 2 of 4 beats -> mem_req=0 and counters=0 next cycle; stray mem_valid is ignored; re-request misses and refills correctly.
REQ-045 Beats with 3 idle cycles between each -> correct line contents; resp_valid exactly once.
REQ-046 NUM_WAYS=1, NUM_SETS=8, WORDS_PER_LINE=8 build: 0x0000 and 0x0040 alternate -> every access misses.

Source files
------------

// File: rtl/param_icache.sv
// Parameterised read-only instruction cache: 1- or 2-way set associative,
// true LRU per set, blocking line fill from a beat-oriented memory port.
module param_icache #(
  parameter int WORD_SIZE      = 16,
  parameter int NUM_SETS       = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_WAYS       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  // Request handshake: a fetch is taken on a rising edge where req_valid and
  // req_ready are both 1; req_addr must be stable in that cycle. resp_valid is
  // a single-cycle pulse that needs no acknowledge.
  input  logic                 req_valid,
  input  logic [WORD_SIZE-1:0] req_addr,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_valid,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 flush,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count,
  output logic [1:0]           fsm_state
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2
  } state_t;

  state_t                state;
  logic                  valid [NUM_WAYS][NUM_SETS];
  logic [TAG_W-1:0]      tags  [NUM_WAYS][NUM_SETS];
  logic [WORD_SIZE-1:0]  lines [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
  logic [NUM_SETS-1:0]   lru;
  logic [WORD_SIZE-1:0]  addr_q;
  logic [WORD_SIZE-1:0]  captured;
  logic [OFF_W-1:0]      beat_cnt;
  logic                  victim;
  logic                  flush_pending;

  logic [OFF_W-1:0]      off;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  hit_way;
  logic                  victim_c;
  logic                  found_free;
  logic [WORD_SIZE-1:0]  hit_word;
  logic                  fill_we;
  logic                  last_beat;

  assign off       = addr_q[OFF_W-1:0];
  assign idx       = addr_q[OFF_W +: IDX_W];
  assign tag       = addr_q[WORD_SIZE-1 -: TAG_W];
  assign fill_we   = (state == FILL) && mem_valid;
  assign last_beat = (beat_cnt == OFF_W'(WORDS_PER_LINE - 1));
  assign req_ready = (state == IDLE) && !flush_pending && !flush;
  assign fsm_state = state;
  assign hit_word  = lines[hit_way][idx][off];

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid[w][idx] && (tags[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // An empty way always wins over the LRU way, lowest way first.
  always_comb begin
    victim_c   = (NUM_WAYS == 2) ? lru[idx] : 1'b0;
    found_free = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_free && !valid[w][idx]) begin
        victim_c   = 1'(w);
        found_free = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fill_we) begin
      lines[victim][idx][beat_cnt] <= mem_data;
      if (last_beat) tags[victim][idx] <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      for (int w = 0; w < NUM_WAYS; w++)
        for (int s = 0; s < NUM_SETS; s++)
          valid[w][s] <= 1'b0;
      lru           <= '0;
      beat_cnt      <= '0;
      flush_pending <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      addr_q        <= '0;
      captured      <= '0;
      victim        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (flush) flush_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (flush_pending) begin
            for (int w = 0; w < NUM_WAYS; w++)
              for (int s = 0; s < NUM_SETS; s++)
                valid[w][s] <= 1'b0;
            flush_pending <= flush;
          end else if (req_valid && req_ready) begin
            addr_q <= req_addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            resp_data  <= hit_word;
            if (NUM_WAYS == 2) lru[idx] <= ~hit_way;
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          end else begin
            state    <= FILL;
            victim   <= victim_c;
            mem_req  <= 1'b1;
            mem_addr <= {addr_q[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
            beat_cnt <= '0;
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end
        end
        FILL: begin
          if (mem_valid) begin
            beat_cnt <= beat_cnt + OFF_W'(1);
            if (beat_cnt == off) captured <= mem_data;
            if (last_beat) begin
              valid[victim][idx] <= 1'b1;
              if (NUM_WAYS == 2) lru[idx] <= ~victim;
              state      <= IDLE;
              mem_req    <= 1'b0;
              resp_valid <= 1'b1;
              resp_data  <= (beat_cnt == off) ? mem_data : captured;
              beat_cnt   <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_icache.sv
// Bench for param_icache: default build plus a direct-mapped 8x8 build, a
// recency-list cache model, and a memory whose word at address a is mem_word(a).
module tb_param_icache;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, mem_valid, flush, sel;
  logic [15:0] req_addr, mem_data;

  logic        rdy0, rv0, mreq0, rdy1, rv1, mreq1;
  logic [15:0] rd0, maddr0, hc0, mc0, rd1, maddr1, hc1, mc1;
  logic [1:0]  st0, st1;

  logic        obs_req_ready, obs_resp_valid, obs_mem_req;
  logic [15:0] obs_resp_data, obs_mem_addr, obs_hits, obs_misses;

  int          tests, fails;
  int          m_wpl, m_sets, m_ways;
  int unsigned res_q [8][$];
  int          exp_hits, exp_misses;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  param_icache u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_addr(req_addr),
    .req_ready(rdy0), .resp_valid(rv0), .resp_data(rd0), .mem_req(mreq0),
    .mem_addr(maddr0), .mem_valid(mem_valid && !sel), .mem_data(mem_data),
    .flush(flush && !sel), .hit_count(hc0), .miss_count(mc0), .fsm_state(st0)
  );

  param_icache #(.WORD_SIZE(16), .NUM_SETS(8), .WORDS_PER_LINE(8), .NUM_WAYS(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_addr(req_addr),
    .req_ready(rdy1), .resp_valid(rv1), .resp_data(rd1), .mem_req(mreq1),
    .mem_addr(maddr1), .mem_valid(mem_valid && sel), .mem_data(mem_data),
    .flush(flush && sel), .hit_count(hc1), .miss_count(mc1), .fsm_state(st1)
  );

  assign obs_req_ready  = sel ? rdy1   : rdy0;
  assign obs_resp_valid = sel ? rv1    : rv0;
  assign obs_resp_data  = sel ? rd1    : rd0;
  assign obs_mem_req    = sel ? mreq1  : mreq0;
  assign obs_mem_addr   = sel ? maddr1 : maddr0;
  assign obs_hits       = sel ? hc1    : hc0;
  assign obs_misses     = sel ? mc1    : mc0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) res_q[s].delete();
  endfunction

  // Each set keeps its resident lines most-recent first; returns 1 on a miss.
  function automatic bit model_access(input logic [15:0] a);
    int unsigned line;
    int          set;
    line = int'(a) / m_wpl;
    set  = int'(line % m_sets);
    for (int i = 0; i < res_q[set].size(); i++) begin
      if (res_q[set][i] == line) begin
        res_q[set].delete(i);
        res_q[set].push_front(line);
        exp_hits++;
        return 1'b0;
      end
    end
    if (res_q[set].size() >= m_ways) void'(res_q[set].pop_back());
    res_q[set].push_front(line);
    exp_misses++;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && obs_resp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected: resp_valid=1 data 0x%0h, expected no response", obs_resp_data);
      end else begin
        check("resp_data", obs_resp_data, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic fetch(input logic [15:0] a, input int gap, input int flush_beat,
                       output bit miss_seen, output logic [15:0] data_seen, output int lat);
    bit          exp_miss, got, addr_checked, flushed;
    int          n, cyc, beat, gcnt;
    logic [15:0] base;
    miss_seen = 1'b0;
    data_seen = '0;
    lat       = 0;
    n = 0;
    while (!obs_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!obs_req_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: req_ready=0 for 50 cycles, expected 1");
      return;
    end
    exp_miss = model_access(a);
    exp_q.push_back(mem_word(a));
    base = a & ~16'(m_wpl - 1);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0; beat = 0; gcnt = 0; got = 0; addr_checked = 0; flushed = 0;
    while (!got && cyc < 300) begin
      flush     = 1'b0;
      mem_valid = 1'b0;
      if (obs_resp_valid) begin
        got       = 1'b1;
        data_seen = obs_resp_data;
      end else begin
        if (obs_mem_req) begin
          miss_seen = 1'b1;
          if (!addr_checked) begin
            check("mem_addr", obs_mem_addr, base);
            addr_checked = 1'b1;
          end
          if (beat < m_wpl) begin
            if (gcnt == gap) begin
              mem_valid = 1'b1;
              mem_data  = mem_word(base + 16'(beat));
              if (beat == flush_beat) begin
                flush   = 1'b1;
                flushed = 1'b1;
              end
              beat++;
              gcnt = 0;
            end else begin
              gcnt++;
            end
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    flush     = 1'b0;
    mem_valid = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: no resp_valid within 300 cycles for addr 0x%0h", a);
      exp_q.delete();
      return;
    end
    lat = cyc + 1;
    check("latency", lat, exp_miss ? 2 + m_wpl * (gap + 1) : 2);
    check("miss_flag", miss_seen, exp_miss);
    check("mem_req_fall", obs_mem_req, 0);
    check("hit_count", obs_hits, exp_hits);
    check("miss_count", obs_misses, exp_misses);
    check("ready_in_resp", obs_req_ready, !flushed);
    if (flushed) model_clear();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ms;
    logic [15:0] d;
    int          lat;
    logic [15:0] seq42 [6];
    bit          miss42 [6];
    tests = 0; fails = 0; sel = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0;
    mem_valid = 1'b0; mem_data = '0; flush = 1'b0;
    m_wpl = 4; m_sets = 4; m_ways = 2;
    model_clear(); exp_hits = 0; exp_misses = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_req_ready", obs_req_ready, 1);
    check("rst_resp_valid", obs_resp_valid, 0);
    check("rst_resp_data", obs_resp_data, 0);
    check("rst_mem_req", obs_mem_req, 0);
    check("rst_mem_addr", obs_mem_addr, 0);
    check("rst_hits", obs_hits, 0);
    check("rst_misses", obs_misses, 0);

    // Cold miss, hit in the same line, then a back-to-back hit.
    fetch(16'h0012, 0, -1, ms, d, lat);
    check("cold_miss", ms, 1);
    check("cold_data", d, 16'h485A);
    check("cold_misses", obs_misses, 1);
    check("cold_lat", lat, 6);
    fetch(16'h0013, 0, -1, ms, d, lat);
    check("warm_hit", ms, 0);
    check("warm_data", d, 16'h495A);
    check("warm_hits", obs_hits, 1);
    check("warm_lat", lat, 2);
    fetch(16'h0011, 0, -1, ms, d, lat);
    check("b2b_hit", ms, 0);
    check("b2b_data", d, 16'h4B5A);

    // LRU replacement within set 0.
    seq42  = '{16'h0000, 16'h0040, 16'h0000, 16'h0080, 16'h0000, 16'h0040};
    miss42 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      fetch(seq42[i], 0, -1, ms, d, lat);
      check("lru_seq_miss", ms, miss42[i]);
    end

    // Flush arriving mid-fill: fill still answers, then everything is gone.
    fetch(16'h0020, 0, 1, ms, d, lat);
    check("flush_fill_miss", ms, 1);
    check("flush_fill_data", d, 16'h7A5A);
    fetch(16'h0020, 0, -1, ms, d, lat);
    check("post_flush_miss", ms, 1);
    fetch(16'h0000, 0, -1, ms, d, lat);
    check("post_flush_old_miss", ms, 1);

    // Slow memory: three idle cycles before each beat.
    fetch(16'h0104, 3, -1, ms, d, lat);
    check("slow_lat", lat, 18);
    @(negedge clk);
    check("slow_resp_once", obs_resp_valid, 0);
    for (int i = 5; i < 8; i++) begin
      fetch(16'h0100 + 16'(i), 0, -1, ms, d, lat);
      check("slow_line_hit", ms, 0);
    end
    fetch(16'h0207, 1, -1, ms, d, lat);
    check("last_word_data", d, 16'h5D58);
    check("last_word_lat", lat, 10);

    // Reset after two of four beats.
    while (!obs_req_ready) @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0030;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_fill_mem_req", obs_mem_req, 1);
    mem_valid = 1'b1;
    mem_data  = mem_word(16'h0030);
    @(negedge clk);
    mem_data  = mem_word(16'h0031);
    @(negedge clk);
    mem_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear(); exp_hits = 0; exp_misses = 0; exp_q.delete();
    check("midrst_mem_req", obs_mem_req, 0);
    check("midrst_hits", obs_hits, 0);
    check("midrst_misses", obs_misses, 0);
    check("midrst_ready", obs_req_ready, 1);
    check("midrst_mem_addr", obs_mem_addr, 0);
    mem_valid = 1'b1;
    mem_data  = 16'hDEAD;
    repeat (2) begin
      @(negedge clk);
      check("stray_resp_valid", obs_resp_valid, 0);
      check("stray_mem_req", obs_mem_req, 0);
    end
    mem_valid = 1'b0;
    fetch(16'h0032, 0, -1, ms, d, lat);
    check("refill_miss", ms, 1);
    check("refill_data", d, 16'h685A);
    check("refill_misses", obs_misses, 1);

    // Direct-mapped 8-set, 8-word build: two conflicting lines thrash.
    sel   = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_wpl = 8; m_sets = 8; m_ways = 1;
    model_clear(); exp_hits = 0; exp_misses = 0; exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      fetch((i % 2) ? 16'h0040 : 16'h0000, 0, -1, ms, d, lat);
      check("dm_thrash_miss", ms, 1);
    end
    check("dm_misses", obs_misses, 6);
    check("dm_hits", obs_hits, 0);
    fetch(16'h0041, 0, -1, ms, d, lat);
    check("dm_hit", ms, 0);
    check("dm_hit_data", d, 16'h1B5A);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
